// File: rtl/booth_mul_pipe.sv
// booth_mul_pipe: sequential radix-4 Booth multiplier with valid/ready on both sides.
//
// Each BUSY cycle recodes UNROLL overlapping 3-bit multiplier windows into
// digits in {-2,-1,0,+1,+2} and adds the shifted partial products into the
// accumulator. An optional word mode multiplies only the low XLEN/2 operand
// bits and finishes in roughly half the cycles. The result is held while the
// consumer stalls, and it reads as zero whenever out_valid is low. A flush
// aborts the operation from BUSY or DONE.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-low
//   in_valid     operand bundle valid
//   in_ready     the block can take an operand bundle (held low during flush)
//   flush        abort the current operation (level-sampled)
//   mulw         word mode: the block uses operand bits [XLEN/2-1:0]
//   mul_signed   11 s*s, 10 s*u, 00 or 01 u*u
//   multiplicand, multiplier   XLEN-bit operands
//   out_valid    result valid
//   out_ready    the consumer takes the result
//   result_hi    product[2*XLEN-1:XLEN], or 0 in word mode
//   result_lo    product[XLEN-1:0], or the sign-extended low word in word mode
module booth_mul_pipe #(
  parameter int XLEN    = 64,
  parameter int UNROLL  = 1,
  parameter bit MULW_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int H      = XLEN / 2;
  // The accumulator holds the exact product of two (XLEN+1)-bit operands.
  localparam int AW     = 2 * XLEN + 2;
  // The multiplier register holds the appended 0, XLEN+1 operand bits and a
  // sign bit. It has enough extra sign bits that every window of one cycle
  // can be indexed directly.
  localparam int MPW    = XLEN + 3 + 2 * UNROLL;
  localparam int D_FULL = H + 1;
  // Digit count for an (H+1)-bit operand. This equals XLEN/4+1 when XLEN is
  // a multiple of 4.
  localparam int D_WORD = (H + 3) / 2;
  localparam int CW     = $clog2(D_FULL + UNROLL + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   counter_q, counter_d;   // digits already summed
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   mcand_q, mcand_d;       // sign-extended, pre-shifted multiplicand
  logic [MPW-1:0]  mplr_q, mplr_d;         // {extended multiplier, 0}, consumed from the LSB
  logic            word_q, word_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] res_hi_q, res_hi_d;
  logic [XLEN-1:0] res_lo_q, res_lo_d;

  logic            accept;
  logic            sign_a, sign_b, word_in;
  logic [AW-1:0]   cap_mcand;
  logic [MPW-1:0]  cap_mplr;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   acc_sum;
  logic [AW-1:0]   pp;
  logic [2:0]      win;
  int              ndig;
  logic            last_iter;

  assign in_ready  = ~flush & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;

  // Operand extension at capture. After this point the sign mode is part of
  // the stored operands, so later changes to mul_signed and mulw have no effect.
  always_comb begin
    sign_a  = mul_signed[1];
    sign_b  = mul_signed[1] & mul_signed[0];
    word_in = MULW_EN & mulw;
    if (word_in) begin
      cap_mcand = {{(AW - H){sign_a & multiplicand[H-1]}}, multiplicand[H-1:0]};
      cap_mplr  = {{(MPW - H - 1){sign_b & multiplier[H-1]}}, multiplier[H-1:0], 1'b0};
    end else begin
      cap_mcand = {{(AW - XLEN){sign_a & multiplicand[XLEN-1]}}, multiplicand};
      cap_mplr  = {{(MPW - XLEN - 1){sign_b & multiplier[XLEN-1]}}, multiplier, 1'b0};
    end
  end

  // Booth recoding and partial-product sum for one BUSY cycle.
  // NOTE: every variable written in this block gets a value before any branch,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    sum  = '0;
    pp   = '0;
    win  = '0;
    ndig = word_q ? D_WORD : D_FULL;
    for (int j = 0; j < UNROLL; j++) begin
      win = mplr_q[2*j +: 3];
      case (win)
        3'b001, 3'b010: pp = mcand_q;
        3'b011:         pp = mcand_q << 1;
        3'b100:         pp = -(mcand_q << 1);
        3'b101, 3'b110: pp = -mcand_q;
        default:        pp = '0;
      endcase
      // Digits past the last one contribute nothing when UNROLL does not divide D.
      if (int'(counter_q) + j < ndig) sum = sum + (pp << (2 * j));
    end
    acc_sum   = acc_q + sum;
    last_iter = (int'(counter_q) + UNROLL >= ndig);
  end

  // Next-state logic. Priority: flush > accept/consume > iterate.
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = BUSY;
          counter_d = '0;
          acc_d     = '0;
          mcand_d   = cap_mcand;
          mplr_d    = cap_mplr;
          word_d    = word_in;
        end
      end
      BUSY: begin
        acc_d     = acc_sum;
        counter_d = counter_q + CW'(UNROLL);
        mcand_d   = mcand_q << (2 * UNROLL);
        mplr_d    = $signed(mplr_q) >>> (2 * UNROLL);
        if (last_iter) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          res_hi_d    = word_q ? '0 : acc_sum[2*XLEN-1:XLEN];
          res_lo_d    = word_q ? {{H{acc_sum[H-1]}}, acc_sum[H-1:0]} : acc_sum[XLEN-1:0];
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          res_hi_d    = '0;
          res_lo_d    = '0;
          state_d     = IDLE;
          // The result is consumed and the next operands captured on the same edge.
          if (accept) begin
            state_d   = BUSY;
            counter_d = '0;
            acc_d     = '0;
            mcand_d   = cap_mcand;
            mplr_d    = cap_mplr;
            word_d    = word_in;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush && state_q != IDLE) begin
      state_d     = IDLE;
      counter_d   = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
      res_hi_d    = '0;
      res_lo_d    = '0;
    end
  end

  // NOTE: the reset is sampled only at the clock edge, and every flop uses <=.
  // All always_ff blocks then see pre-edge values, whatever order the
  // simulator runs them in.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      word_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
    end
  end

endmodule

// File: doc/booth_mul_pipe.md
Name: booth_mul_pipe

Overview:
Parametrised sequential radix-4 Booth multiplier, successor to the fixed 64-bit iterative multiplier in the execute-stage MDU. Adds an XLEN parameter, a configurable number of partial products per cycle (UNROLL), and an early-terminating 32-bit word mode. Adds full valid/ready handshakes on both sides with result hold under backpressure, plus a flush that aborts at any point.

Parameters:
XLEN, 64, operand width; even, >= 8.
UNROLL, 1, Booth digits accumulated per BUSY cycle; 1, 2, 4 or 8.
MULW_EN, 1, enables the word mode; when 0, mulw is ignored and treated as 0.

Ports:
clock  in  1  sole clock, rising edge.
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
in_valid  in  1  operand bundle valid.
in_ready  out  1  block can accept an operand bundle.
flush  in  1  abort the current operation, level-sampled.
mulw  in  1  word mode: use operand bits [XLEN/2-1:0].
mul_signed  in  2  11 = signed x signed; 10 = signed multiplicand x unsigned multiplier; 00 = unsigned x unsigned; 01 = treated as 00.
multiplicand  in  XLEN  multiplicand.
multiplier  in  XLEN  multiplier.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
result_hi  out  XLEN  product[2*XLEN-1:XLEN].
result_lo  out  XLEN  product[XLEN-1:0].

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, counter=0, accumulator=0, operand registers=0. After reset: in_ready=1, out_valid=0, result_hi=0, result_lo=0. Reset overrides every other input, including mid-operation.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on accept.
  - BUSY -> DONE when the last digit group has been summed.
  - DONE -> IDLE on out_ready without a new accept.
  - DONE -> BUSY on out_ready together with a new accept.
- Accept = in_valid & in_ready. in_ready = (state==IDLE) | (state==DONE & out_ready); in_ready is forced 0 while flush==1.
- Operand capture on accept:
  - Each operand is extended by one bit: sign bit if its signed flag is set, else 0. Width W = XLEN+1, or XLEN/2+1 in word mode.
  - Multiplier is shifted left by one with a 0 LSB and padded to an even width.
  - mul_signed and mulw are latched; input changes during BUSY have no effect.
- Digit count D = XLEN/2+1 (full) or XLEN/4+1 (word). BUSY cycle count N = ceil(D/UNROLL).
- Each BUSY cycle:
  - Recode UNROLL overlapping 3-bit multiplier windows into digits {-2,-1,0,+1,+2}.
  - Generate partial products from the captured multiplicand, sign-extended to 2*XLEN+2 bits.
  - Shift each partial product by 2*digit_index and add it to the accumulator.
  - Digits with index >= D contribute 0, covering UNROLL not dividing D.
- Latency: accept edge at cycle T; out_valid=1 from cycle T+N+1. Full XLEN=64, UNROLL=1: N=33, out_valid at T+34. Word mode: N=17.
- Result mapping:
  - Full mode: {result_hi, result_lo} = product[2*XLEN-1:0]. The product is exact modulo 2^(2*XLEN) for all three sign modes.
  - Word mode: result_lo = sign-extension of product[XLEN/2-1:0] to XLEN; result_hi = 0.
- Output hold: result_hi, result_lo and out_valid stay stable while out_valid=1 & out_ready=0. result_hi and result_lo are 0 whenever out_valid=0.
- Back-to-back: in DONE with out_ready=1 and in_valid=1, the result is consumed and the new operands captured on the same edge. out_valid drops the next cycle.
- Flush: flush==1 at an edge in BUSY or DONE forces IDLE and clears counter and accumulator. out_valid=0 next cycle and any pending result is discarded. A flush in IDLE has no effect, and no accept occurs in a flush cycle.
- Simultaneous events, priority: reset > flush > accept/consume > iterate.

Test Plan:
- Unsigned, XLEN=64, UNROLL=1: mul_signed=00, 0xFFFF_FFFF_FFFF_FFFF x 0xFFFF_FFFF_FFFF_FFFF -> out_valid exactly 34 cycles after accept; hi=0xFFFF_FFFF_FFFF_FFFE, lo=0x0000_0000_0000_0001.
- Signed modes:
  - mul_signed=11, -3 x 5 -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFF1.
  - mul_signed=10, multiplicand=-1, multiplier=0xFFFF_FFFF_FFFF_FFFF -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0x0000_0000_0000_0001.
- Word mode: mulw=1, mul_signed=11, 0x7FFF_FFFF x 2 -> out_valid 18 cycles after accept; lo=0xFFFF_FFFF_FFFF_FFFE, hi=0. Upper operand bits set to garbage must not change the result.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs constant, in_ready=0.
  - Then assert out_ready=1 with in_valid=1 (7 x 6) -> first result consumed, second accepted the same edge; lo=42 after 34 cycles.
- Flush and reset:
  - Flush on BUSY cycle 10 -> next cycle IDLE, in_ready=1, out_valid never rises; the following op (3 x 4) returns 12.
  - Flush in DONE -> out_valid=0 next cycle.
  - reset=0 mid-BUSY -> all outputs 0 / in_ready=1 after the edge.
- UNROLL=4 build, full mode: random signed/unsigned operands vs reference model -> out_valid 10 cycles after accept (N=9), bit-exact results over 10k vectors.
